// File: rtl/rsa_control.sv
// RSA engine: derives n, phi and d = 65537^-1 mod phi from p and q, then runs
// square-and-multiply modular exponentiation. Each phase is restarted by its own async reset.
module rsa_control #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_inverter,
    input  logic               reset_mod_exp,
    input  logic [WIDTH-1:0]   p,
    input  logic [WIDTH-1:0]   q,
    input  logic               encrypt_decrypt,
    input  logic [2*WIDTH-1:0] msg_in,
    output logic               inverter_finish,
    output logic [2*WIDTH-1:0] msg_out,
    output logic               mod_exp_finish
);
    localparam int NW  = 2 * WIDTH;
    localparam int UW  = (NW > 17) ? NW : 17;
    localparam int CW  = UW + 3;
    localparam int MCW = $clog2(WIDTH + 1);
    localparam int ECW = $clog2(NW);
    localparam logic [UW-1:0]        E_U = UW'(65537);
    localparam logic signed [CW-1:0] E_C = CW'(65537);

    typedef enum logic [2:0] {K_LOAD, K_MUL, K_INIT, K_GCD, K_FIX, K_DONE} kstate_t;
    typedef enum logic [2:0] {X_LOAD, X_RED, X_SQR, X_MUL, X_DONE} xstate_t;

    kstate_t k_state, k_next;
    logic [NW-1:0]        mc_n, mc_f, n_reg, phi_reg, d_reg;
    logic [WIDTH-1:0]     mp_n, mp_f, p_dec, q_dec;
    logic [MCW-1:0]       k_cnt;
    logic [UW-1:0]        gu, gv;
    logic signed [CW-1:0] ga, gb, gc, gd, phi_c;

    assign p_dec = p - WIDTH'(1);
    assign q_dec = q - WIDTH'(1);
    assign phi_c = $signed({{(CW-NW){1'b0}}, phi_reg});
    assign inverter_finish = (k_state == K_DONE);

    always_comb begin
        k_next = k_state;
        case (k_state)
            K_LOAD: k_next = K_MUL;
            K_MUL:  if (k_cnt == MCW'(WIDTH - 1)) k_next = K_INIT;
            K_INIT: k_next = (phi_reg == '0) ? K_DONE : K_GCD;
            K_GCD:  if (gu == '0) k_next = (gv == UW'(1)) ? K_FIX : K_DONE;
            K_FIX:  if (!gc[CW-1] && gc < phi_c) k_next = K_DONE;
            default: k_next = k_state;
        endcase
    end

    // Binary extended GCD keeps ga*e + gb*phi = gu and gc*e + gd*phi = gv;
    // when gu reaches 0, gv is the gcd and gc is the inverse before range fix-up.
    always_ff @(posedge clk or posedge reset_inverter) begin
        if (reset_inverter) begin
            k_state <= K_LOAD;
            mc_n <= '0; mc_f <= '0; mp_n <= '0; mp_f <= '0; k_cnt <= '0;
            n_reg <= '0; phi_reg <= '0; d_reg <= '0;
            gu <= '0; gv <= '0; ga <= '0; gb <= '0; gc <= '0; gd <= '0;
        end else begin
            k_state <= k_next;
            case (k_state)
                K_LOAD: begin
                    mc_n <= NW'(p);      mp_n <= q;
                    mc_f <= NW'(p_dec);  mp_f <= q_dec;
                    n_reg <= '0; phi_reg <= '0; k_cnt <= '0;
                end
                K_MUL: begin
                    if (mp_n[0]) n_reg <= n_reg + mc_n;
                    if (mp_f[0]) phi_reg <= phi_reg + mc_f;
                    mc_n <= mc_n << 1;  mp_n <= mp_n >> 1;
                    mc_f <= mc_f << 1;  mp_f <= mp_f >> 1;
                    k_cnt <= k_cnt + MCW'(1);
                end
                K_INIT: begin
                    gu <= E_U; gv <= UW'(phi_reg);
                    ga <= CW'(1); gb <= '0; gc <= '0; gd <= CW'(1);
                    d_reg <= '0;
                end
                K_GCD: if (gu != '0) begin
                    if (!gu[0]) begin
                        gu <= gu >> 1;
                        if (!ga[0] && !gb[0]) begin ga <= ga >>> 1; gb <= gb >>> 1; end
                        else begin ga <= (ga + phi_c) >>> 1; gb <= (gb - E_C) >>> 1; end
                    end else if (!gv[0]) begin
                        gv <= gv >> 1;
                        if (!gc[0] && !gd[0]) begin gc <= gc >>> 1; gd <= gd >>> 1; end
                        else begin gc <= (gc + phi_c) >>> 1; gd <= (gd - E_C) >>> 1; end
                    end else if (gu >= gv) begin
                        gu <= gu - gv; ga <= ga - gc; gb <= gb - gd;
                    end else begin
                        gv <= gv - gu; gc <= gc - ga; gd <= gd - gb;
                    end
                end
                K_FIX: begin
                    if (gc[CW-1])        gc <= gc + phi_c;
                    else if (gc >= phi_c) gc <= gc - phi_c;
                    else                  d_reg <= gc[NW-1:0];
                end
                default: ;
            endcase
        end
    end

    // One bit of an interleaved modular product: r = 2r + bit*b mod m, all terms < 2m.
    function automatic logic [NW-1:0] mm_step(input logic [NW-1:0] r, input logic bit_in,
                                              input logic [NW-1:0] b, input logic [NW-1:0] m);
        logic [NW:0] t;
        t = {r, 1'b0};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        if (bit_in) t = t + {1'b0, b};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        return t[NW-1:0];
    endfunction

    xstate_t x_state, x_next;
    logic [NW-1:0]  nr, er, mm_a, mm_b, mm_r, base, mm_next, one;
    logic [ECW-1:0] mm_cnt, bit_idx;
    logic           mm_last, advance;

    assign mm_next = mm_step(mm_r, mm_a[NW-1], mm_b, nr);
    assign mm_last = (mm_cnt == ECW'(NW - 1));
    assign one     = (nr == NW'(1)) ? '0 : NW'(1);
    assign advance = (x_state == X_MUL) || (x_state == X_SQR && !er[bit_idx]);

    always_comb begin
        x_next = x_state;
        case (x_state)
            X_LOAD: x_next = X_RED;
            X_RED:  if (mm_last) x_next = X_SQR;
            X_SQR, X_MUL: if (mm_last) begin
                if (!advance)              x_next = X_MUL;
                else if (bit_idx == '0)    x_next = X_DONE;
                else                       x_next = X_SQR;
            end
            default: x_next = x_state;
        endcase
    end

    always_ff @(posedge clk or posedge reset_mod_exp) begin
        if (reset_mod_exp) begin
            x_state <= X_LOAD;
            nr <= '0; er <= '0; mm_a <= '0; mm_b <= '0; mm_r <= '0; base <= '0;
            mm_cnt <= '0; bit_idx <= '0;
            msg_out <= '0; mod_exp_finish <= 1'b0;
        end else begin
            x_state <= x_next;
            if (x_state == X_LOAD) begin
                nr   <= n_reg;
                er   <= encrypt_decrypt ? d_reg : NW'(65537);
                mm_a <= msg_in; mm_b <= NW'(1); mm_r <= '0;
                mm_cnt <= '0; bit_idx <= ECW'(NW - 1);
            end else if (x_state inside {X_RED, X_SQR, X_MUL}) begin
                if (!mm_last) begin
                    mm_r <= mm_next; mm_a <= mm_a << 1; mm_cnt <= mm_cnt + ECW'(1);
                end else begin
                    mm_r <= '0; mm_cnt <= '0;
                    if (x_state == X_RED) begin
                        base <= mm_next; mm_a <= one; mm_b <= one;
                    end else if (!advance) begin
                        mm_a <= mm_next; mm_b <= base;
                    end else if (bit_idx == '0) begin
                        msg_out <= mm_next; mod_exp_finish <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx - ECW'(1); mm_a <= mm_next; mm_b <= mm_next;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rsa_control.sv
// Directed bench for rsa_control: a 16-bit instance on the 61/53 textbook key and a
// 32-bit instance for the degenerate-d key and a full-width round trip.
module tb_rsa_control;
    localparam int KB16 = 32*16 + 64;
    localparam int XB16 = 2*32*34 + 64 + 16;
    localparam int KB32 = 32*32 + 64;
    localparam int XB32 = 2*64*66 + 128 + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ri16, rx16, ed16, if16, xf16;
    logic [15:0] p16, q16;
    logic [31:0] mi16, mo16;
    logic        ri32, rx32, ed32, if32, xf32;
    logic [31:0] p32, q32;
    logic [63:0] mi32, mo32;

    rsa_control #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_inverter(ri16), .reset_mod_exp(rx16), .p(p16), .q(q16),
        .encrypt_decrypt(ed16), .msg_in(mi16), .inverter_finish(if16),
        .msg_out(mo16), .mod_exp_finish(xf16));

    rsa_control #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_inverter(ri32), .reset_mod_exp(rx32), .p(p32), .q(q32),
        .encrypt_decrypt(ed32), .msg_in(mi32), .inverter_finish(if32),
        .msg_out(mo32), .mod_exp_finish(xf32));

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic key16(input logic [15:0] pp, input logic [15:0] qq);
        p16 = pp; q16 = qq;
        @(negedge clk) ri16 = 1'b1;
        @(negedge clk) ri16 = 1'b0;
        for (int i = 0; i < KB16 && if16 !== 1'b1; i++) @(negedge clk);
        chk("key16_done", 64'(if16), 64'd1);
    endtask

    task automatic start16(input logic ed, input logic [31:0] m);
        ed16 = ed; mi16 = m;
        @(negedge clk) rx16 = 1'b1;
        @(negedge clk) rx16 = 1'b0;
    endtask

    task automatic wait16();
        for (int i = 0; i < XB16 && xf16 !== 1'b1; i++) @(negedge clk);
        chk("exp16_done", 64'(xf16), 64'd1);
    endtask

    task automatic exp16(input logic ed, input logic [31:0] m, input logic [31:0] exp, input string tag);
        start16(ed, m);
        wait16();
        chk(tag, 64'(mo16), 64'(exp));
    endtask

    task automatic key32(input logic [31:0] pp, input logic [31:0] qq);
        p32 = pp; q32 = qq;
        @(negedge clk) ri32 = 1'b1;
        @(negedge clk) ri32 = 1'b0;
        for (int i = 0; i < KB32 && if32 !== 1'b1; i++) @(negedge clk);
        chk("key32_done", 64'(if32), 64'd1);
    endtask

    task automatic exp32(input logic ed, input logic [63:0] m);
        ed32 = ed; mi32 = m;
        @(negedge clk) rx32 = 1'b1;
        @(negedge clk) rx32 = 1'b0;
        for (int i = 0; i < XB32 && xf32 !== 1'b1; i++) @(negedge clk);
        chk("exp32_done", 64'(xf32), 64'd1);
    endtask

    initial begin
        logic [63:0]  nexp, ct;
        logic [127:0] phi;
        logic [63:0]  msgs [2];

        ri16 = 1'b1; rx16 = 1'b1; ri32 = 1'b1; rx32 = 1'b1;
        p16 = '0; q16 = '0; ed16 = 1'b0; mi16 = '0;
        p32 = '0; q32 = '0; ed32 = 1'b0; mi32 = '0;
        repeat (2) @(negedge clk);
        chk("rst_if16", 64'(if16), 64'd0);
        chk("rst_xf16", 64'(xf16), 64'd0);
        chk("rst_mo16", 64'(mo16), 64'd0);
        chk("rst_if32", 64'(if32), 64'd0);
        chk("rst_mo32", mo32, 64'd0);
        ri16 = 1'b0; rx16 = 1'b0; ri32 = 1'b0; rx32 = 1'b0;

        // textbook key: n = 3233, phi = 3120, d = 2753
        key16(16'd61, 16'd53);
        chk("n16", 64'(dut16.n_reg), 64'd3233);
        chk("d16", 64'(dut16.d_reg), 64'd2753);
        exp16(1'b0, 32'd65, 32'd2790, "enc65");
        repeat (20) @(negedge clk);
        chk("hold_mo16", 64'(mo16), 64'd2790);
        chk("hold_xf16", 64'(xf16), 64'd1);
        exp16(1'b1, 32'd2790, 32'd65,   "dec2790");
        exp16(1'b0, 32'd0,    32'd0,    "enc0");
        exp16(1'b1, 32'd1,    32'd1,    "dec1");
        exp16(1'b0, 32'd3298, 32'd2790, "enc_ge_n");

        // async clear of held outputs, then abort a run part-way
        #2 rx16 = 1'b1;
        #1 chk("aclr_mo16", 64'(mo16), 64'd0);
        chk("aclr_xf16", 64'(xf16), 64'd0);
        @(negedge clk) rx16 = 1'b0;
        ed16 = 1'b0; mi16 = 32'd65;
        repeat (300) @(negedge clk);
        chk("midrun_busy", 64'(xf16), 64'd0);
        rx16 = 1'b1;
        #1 chk("abort_mo16", 64'(mo16), 64'd0);
        chk("abort_xf16", 64'(xf16), 64'd0);
        @(negedge clk) rx16 = 1'b0;
        wait16();
        chk("restart_enc65", 64'(mo16), 64'd2790);

        // rekey during a run must not disturb the latched key; new key has n = 1
        start16(1'b1, 32'd2790);
        repeat (5) @(negedge clk);
        p16 = 16'd1; q16 = 16'd1;
        ri16 = 1'b1;
        @(negedge clk) ri16 = 1'b0;
        wait16();
        chk("latched_key", 64'(mo16), 64'd65);
        for (int i = 0; i < KB16 && if16 !== 1'b1; i++) @(negedge clk);
        chk("key_n1_done", 64'(if16), 64'd1);
        chk("n16_one", 64'(dut16.n_reg), 64'd1);
        chk("d16_zero", 64'(dut16.d_reg), 64'd0);
        exp16(1'b1, 32'd5, 32'd0, "dec_n1");
        exp16(1'b0, 32'd5, 32'd0, "enc_n1");

        // phi = 786444 = 12 * 65537, so d = 0 and decryption yields 1
        key32(32'd131075, 32'd7);
        chk("n32_deg", 64'(dut32.n_reg), 64'd917525);
        chk("d32_deg", 64'(dut32.d_reg), 64'd0);
        exp32(1'b1, 64'd12345);
        chk("dec_d0", mo32, 64'd1);

        // full-width key from the two largest 32-bit primes
        key32(32'd4294967291, 32'd4294967279);
        nexp = 64'(32'd4294967291) * 64'(32'd4294967279);
        chk("n32", dut32.n_reg, nexp);
        phi = 128'(32'd4294967290) * 128'(32'd4294967278);
        chk("d32_inv", 64'((128'(65537) * 128'(dut32.d_reg)) % phi), 64'd1);
        chk("d32_range", 64'(128'(dut32.d_reg) < phi), 64'd1);
        exp32(1'b0, nexp - 64'd1);
        chk("enc_nm1", mo32, nexp - 64'd1);
        msgs[0] = 64'h0123_4567_89AB_CDEF;
        msgs[1] = 64'd2;
        for (int k = 0; k < 2; k++) begin
            exp32(1'b0, msgs[k]);
            ct = mo32;
            exp32(1'b1, ct);
            chk("roundtrip32", mo32, msgs[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
